// File: rtl/mips_pkg.sv
// mips_pkg: instruction kinds, opcode/funct constants and loader states.
// IMEM_LOADER_NOP_PAD_EN adds the PAD loader state.
package mips_pkg;
  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW, K_BEQ, K_ADDI, K_J
  } kind_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  typedef enum logic [1:0] {
    S_LOAD,
`ifdef IMEM_LOADER_NOP_PAD_EN
    S_PAD,
`endif
    S_DONE,
    S_ERR
  } state_e;
endpackage

// File: rtl/instr_encoder.sv
// instr_encoder: combinational descriptor-to-MIPS-word encoder with kind validity flag.
module instr_encoder
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        kind_valid
);
  logic [31:0] r_base;
  logic [31:0] i_base;
  assign r_base = {OP_RTYPE, rs, rt, rd, 5'd0, 6'd0};
  assign i_base = {6'd0, rs, rt, imm[15:0]};
  always_comb begin
    word = 32'd0;
    kind_valid = 1'b1;
    case (kind_e'(kind))
      K_ADD:   word = r_base | {26'd0, FN_ADD};
      K_SUB:   word = r_base | {26'd0, FN_SUB};
      K_AND:   word = r_base | {26'd0, FN_AND};
      K_OR:    word = r_base | {26'd0, FN_OR};
      K_SLT:   word = r_base | {26'd0, FN_SLT};
      K_LW:    word = i_base | {OP_LW, 26'd0};
      K_SW:    word = i_base | {OP_SW, 26'd0};
      K_BEQ:   word = i_base | {OP_BEQ, 26'd0};
      K_ADDI:  word = i_base | {OP_ADDI, 26'd0};
      K_J:     word = {OP_J, imm};
      default: kind_valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: encodes descriptors into sequential imem writes, holding the core until loaded.
// IMEM_LOADER_NOP_PAD_EN fills the unwritten tail of memory with nops before release.
module imem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              cpu_run,
  output logic              load_err
);
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  state_e            state_d, state_q;
  logic [ADDR_W:0]   count_d, count_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [31:0]       wdata_d, wdata_q;
  logic              err_d, err_q;
  logic              run_d, run_q;
  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              xfer;
  logic              full;
  instr_encoder u_enc (
    .kind(in_kind), .rs(in_rs), .rt(in_rt), .rd(in_rd), .imm(in_imm),
    .word(enc_word), .kind_valid(enc_ok)
  );
  assign xfer = in_valid && state_q == S_LOAD;
  assign full = count_q == LAST_ADDR;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    run_d   = state_q == S_DONE;
    if (xfer && !enc_ok) begin
      err_d   = 1'b1;
      state_d = S_ERR;
    end else if (xfer) begin
      we_d    = 1'b1;
      addr_d  = count_q[ADDR_W-1:0];
      wdata_d = enc_word;
      count_d = count_q + 1'b1;
`ifdef IMEM_LOADER_NOP_PAD_EN
      state_d = full ? S_DONE : in_last ? S_PAD : S_LOAD;
`else
      state_d = (full || in_last) ? S_DONE : S_LOAD;
`endif
    end
`ifdef IMEM_LOADER_NOP_PAD_EN
    else if (state_q == S_PAD) begin
      we_d    = 1'b1;
      addr_d  = count_q[ADDR_W-1:0];
      wdata_d = 32'd0;
      count_d = count_q + 1'b1;
      state_d = full ? S_DONE : S_PAD;
    end
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end
  assign in_ready   = state_q == S_LOAD;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign cpu_run    = run_q;
  assign load_err   = err_q;
endmodule
